// File: rtl/ceres_param.sv
// ceres_param: shared parameters and types for the memory-side blocks.
//   BLK_SIZE / WORD_W : cache-line width and memory word width (bits)
//   rw_size_e         : access-size encoding carried on lowX requests
//   lowX_req_t        : line-wide request from the instruction/data arbiter
//   lowX_res_t        : line-wide response back to the arbiter
//   bridge_state_e    : mem_line_bridge FSM states
package ceres_param;

    localparam int XLEN     = 32;
    localparam int BLK_SIZE = 128;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        NO_SIZE = 2'b00,
        BYTE    = 2'b01,
        HALF    = 2'b10,
        WORD    = 2'b11
    } rw_size_e;

    // rw: 1 = write, 0 = read
    typedef struct packed {
        logic [XLEN-1:0]     addr;
        logic                valid;
        logic                ready;
        logic                rw;
        rw_size_e            rw_size;
        logic [BLK_SIZE-1:0] data;
        logic                uncached;
    } lowX_req_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [BLK_SIZE-1:0] blk;
    } lowX_res_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        WAIT_R = 2'b10,
        RESP   = 2'b11
    } bridge_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: places a sub-word store onto its byte lanes.
//   size_i  : access size (NO_SIZE/BYTE/HALF/WORD)
//   off_i   : byte offset within the word (addr[1:0])
//   data_i  : store data, right-justified
//   wstrb_o : byte strobes
//   wdata_o : data shifted onto the selected lanes
// Misaligned halves/words are aligned down silently.
module mem_lane_align
    import ceres_param::*;
#(
    parameter int WORD_W = ceres_param::WORD_W
) (
    input  rw_size_e            size_i,
    input  logic [1:0]          off_i,
    input  logic [WORD_W-1:0]   data_i,
    output logic [WORD_W/8-1:0] wstrb_o,
    output logic [WORD_W-1:0]   wdata_o
);

    localparam int STRB_W = WORD_W / 8;

    logic [1:0] half_off;
    assign half_off = {off_i[1], 1'b0};

    always_comb begin
        wstrb_o = '1;
        wdata_o = data_i;
        case (size_i)
            BYTE: begin
                wstrb_o = STRB_W'(1) << off_i;
                wdata_o = data_i << {off_i, 3'b000};
            end
            HALF: begin
                wstrb_o = STRB_W'(3) << half_off;
                wdata_o = data_i << {half_off, 3'b000};
            end
            default: begin
                wstrb_o = '1;
                wdata_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_line_bridge.sv
// mem_line_bridge: serialises line-wide lowX requests into word beats on a
// valid/ready memory port and reassembles read words into a line response.
//   clk_i, rst_ni          : clock, async active-low reset
//   mem_bus_req_i          : arbiter request, held until mem_bus_res_o.valid
//   mem_bus_res_o          : 1-cycle completion pulse, ready in IDLE, read line
//   mem_req_valid_o/ready_i: beat handshake
//   mem_addr_o, mem_we_o, mem_wstrb_o, mem_wdata_o : beat payload
//   mem_rvalid_i, mem_rdata_i : read return (only honoured in WAIT_R)
module mem_line_bridge
    import ceres_param::*;
#(
    parameter int BLK_SIZE = ceres_param::BLK_SIZE,
    parameter int WORD_W   = ceres_param::WORD_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  lowX_req_t           mem_bus_req_i,
    output lowX_res_t           mem_bus_res_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [31:0]         mem_addr_o,
    output logic                mem_we_o,
    output logic [WORD_W/8-1:0] mem_wstrb_o,
    output logic [WORD_W-1:0]   mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic [WORD_W-1:0]   mem_rdata_i
);

    localparam int BEATS   = BLK_SIZE / WORD_W;
    localparam int BOFFSET = $clog2(BLK_SIZE / 8);
    localparam int BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STRB_W  = WORD_W / 8;

    bridge_state_e                  state_q, state_d;
    logic [BCW-1:0]                 beat_q, beat_d;
    logic [BCW-1:0]                 last_q, last_d;   // index of final beat
    logic [BCW-1:0]                 lane_q, lane_d;   // uncached read lane
    logic                           unc_q, unc_d;
    logic                           we_q, we_d;
    logic [31:0]                    addr_q, addr_d;
    logic [STRB_W-1:0]              strb_q, strb_d;
    logic [WORD_W-1:0]              wdata_q, wdata_d;
    logic [BEATS-1:0][WORD_W-1:0]   line_q, line_d;   // writeback data
    logic [BEATS-1:0][WORD_W-1:0]   buf_q, buf_d;     // read line buffer

    logic [STRB_W-1:0] al_strb;
    logic [WORD_W-1:0] al_wdata;
    logic [BCW-1:0]    beat_nx;
    logic              unused_req_ready;

    assign unused_req_ready = mem_bus_req_i.ready;
    assign beat_nx          = beat_q + BCW'(1);

    mem_lane_align #(.WORD_W(WORD_W)) u_align (
        .size_i  (mem_bus_req_i.rw_size),
        .off_i   (mem_bus_req_i.addr[1:0]),
        .data_i  (mem_bus_req_i.data[WORD_W-1:0]),
        .wstrb_o (al_strb),
        .wdata_o (al_wdata)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        lane_d  = lane_q;
        unc_d   = unc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        line_d  = line_q;
        buf_d   = buf_q;

        case (state_q)
            IDLE: begin
                if (mem_bus_req_i.valid) begin
                    state_d = ISSUE;
                    beat_d  = '0;
                    unc_d   = mem_bus_req_i.uncached;
                    we_d    = mem_bus_req_i.rw;
                    last_d  = mem_bus_req_i.uncached ? '0 : BCW'(BEATS - 1);
                    lane_d  = mem_bus_req_i.addr[BOFFSET-1:2];
                    line_d  = mem_bus_req_i.data;
                    buf_d   = '0;
                    if (mem_bus_req_i.uncached)
                        addr_d = {mem_bus_req_i.addr[31:2], 2'b00};
                    else
                        addr_d = {mem_bus_req_i.addr[31:BOFFSET], {BOFFSET{1'b0}}};
                    if (!mem_bus_req_i.rw) begin
                        strb_d  = '0;
                        wdata_d = '0;
                    end else if (mem_bus_req_i.uncached) begin
                        strb_d  = al_strb;
                        wdata_d = al_wdata;
                    end else begin
                        strb_d  = '1;
                        wdata_d = mem_bus_req_i.data[WORD_W-1:0];
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready_i) begin
                    if (!we_q) begin
                        state_d = WAIT_R;
                    end else if (beat_q == last_q) begin
                        state_d = RESP;
                    end else begin
                        // write beats stream without waiting for anything
                        beat_d  = beat_nx;
                        addr_d  = addr_q + 32'd4;
                        wdata_d = line_q[beat_nx];
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    buf_d[unc_q ? lane_q : beat_q] = mem_rdata_i;
                    if (beat_q == last_q) begin
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                        beat_d  = beat_nx;
                        addr_d  = addr_q + 32'd4;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= '0;
            lane_q  <= '0;
            unc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            line_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            lane_q  <= lane_d;
            unc_q   <= unc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
        end
    end

    assign mem_req_valid_o = (state_q == ISSUE);
    assign mem_addr_o      = addr_q;
    assign mem_we_o        = we_q;
    assign mem_wstrb_o     = strb_q;
    assign mem_wdata_o     = wdata_q;

    always_comb begin
        mem_bus_res_o       = '0;
        mem_bus_res_o.valid = (state_q == RESP);
        mem_bus_res_o.ready = (state_q == IDLE);
        mem_bus_res_o.blk   = buf_q;
    end

endmodule

// File: doc/mem_line_bridge.md
# mem_line_bridge

Downstream neighbour of the instruction/data memory arbiter. It consumes the single line-wide `lowX_req_t` request stream and serialises each request into 32-bit word beats on a simple valid/ready memory port. For reads it reassembles the returned words into one `lowX_res_t` line response. It is the only block between the arbiter and the external memory or peripheral word port.

## Interface
- `BLK_SIZE`, default `ceres_param::BLK_SIZE` (128): cache-line width in bits; must be a multiple of `WORD_W`.
- `WORD_W`, default 32: memory-port data width.
- Derived: `BEATS = BLK_SIZE/WORD_W`; `BOFFSET = $clog2(BLK_SIZE/8)`.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `mem_bus_req_i` in `lowX_req_t`: arbiter request (`addr`, `valid`, `ready`, `rw`, `rw_size`, `data`, `uncached`); held stable by the arbiter until `mem_bus_res_o.valid`.
- `mem_bus_res_o` out `lowX_res_t`: `valid` is a 1-cycle completion pulse; `ready` is high in IDLE; `blk` carries the read line.
- `mem_req_valid_o` out 1: beat request valid.
- `mem_req_ready_i` in 1: memory accepts the beat.
- `mem_addr_o` out 32: word-aligned beat address.
- `mem_we_o` out 1: 1 = write beat.
- `mem_wstrb_o` out `WORD_W/8`: byte strobes.
- `mem_wdata_o` out `WORD_W`: write data.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in `WORD_W`: read data.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_R, RESP.
- **IDLE:** if `mem_bus_req_i.valid`, capture the request and go to ISSUE.
  - Beat count and kind:
    - Cached (`uncached=0`) → `BEATS` beats.
    - Uncached → 1 beat.
  - Beat address:
    - Cached: base = `addr` with the low `BOFFSET` bits cleared; beat i uses base + 4·i.
    - Uncached: `addr` with bits [1:0] cleared.
- **ISSUE:** drive `mem_req_valid_o=1`. On handshake (`valid && ready`):
  - Read → WAIT_R.
  - Write, not last beat → increment beat counter, stay in ISSUE.
  - Write, last beat → RESP.
- **WAIT_R:** `mem_req_valid_o=0`. On `mem_rvalid_i`:
  - Store `mem_rdata_i` into line buffer lane i.
  - Last beat → RESP; otherwise → ISSUE with i+1.
  - `mem_rvalid_i` in any other state is ignored.
- **RESP:** `mem_bus_res_o.valid=1` for exactly one cycle; `blk` = line buffer; then IDLE. The buffer is cleared at each capture.
- **Cached write (line writeback):** full strobes; beat i data = `data[i*WORD_W +: WORD_W]`.
- **Uncached write:**
  - Strobes by size:
    - BYTE → `0001 << addr[1:0]`.
    - HALF → `0011 << {addr[1],1'b0}`.
    - WORD or NO_SIZE → `1111`.
  - `wdata = data[31:0] << (8·addr[1:0])`. For HALF the shift uses `{addr[1],0}`; for WORD the shift is 0. Misaligned access is aligned down, with no error.
- **Uncached read:** the word lands in lane `addr[BOFFSET-1:2]` of `blk`; other lanes are 0.
- Exactly one read beat is outstanding at a time. Write beats may issue back-to-back.
- A request arriving while not in IDLE is not sampled; it is taken on the first IDLE cycle after RESP.

## Timing
- **Reset values (async, immediate):** state IDLE; `mem_req_valid_o=0`, `mem_we_o=0`, `mem_wstrb_o=0`, `mem_addr_o=0`, `mem_wdata_o=0`; `mem_bus_res_o.valid=0`, `mem_bus_res_o.blk=0`; beat counter 0.
- **Reset mid-transfer:** the transfer is abandoned, with no response pulse. The arbiter resets in the same domain.
- **Zero-wait memory** (ready always 1; rvalid the cycle after the handshake):
  - Capture at cycle 0.
  - Cached read: beat i handshake at cycle 1+2i; `res.valid` at cycle 2·BEATS+1 (9 for 4 beats).
  - Cached write: handshakes at cycles 1..BEATS; `res.valid` at cycle BEATS+1.
  - Uncached read: `res.valid` at cycle 3. Uncached write: `res.valid` at cycle 2.
- **Back-to-back requests:** the cycle after RESP the FSM is IDLE. The arbiter's request valid is low then, because it clears on `res.valid`; the next request is captured on the first cycle it is valid.
- **Stalls:** `mem_req_ready_i` low holds address, strobes and data stable. Holding `mem_rvalid_i` low extends WAIT_R indefinitely; there is no timeout.
- **Output timing:** all outputs are registered or decoded from state only; no combinational path from `mem_bus_req_i` to any output.

## Structure
- Add to `ceres_param`:
  - `WORD_W`.
  - A `bridge_state_e` enum.
- `rw_size` encodings (NO_SIZE/BYTE/HALF/WORD) stay in `ceres_param`.
- One combinational sub-module, `mem_lane_align`: maps (`rw_size`, `addr[1:0]`, `data[31:0]`) to (`wstrb`, `wdata`). It is reused by the future peripheral bridge.

## Test plan
- **Cached read** at `0x8000_0014` (BLK 128), memory returns `0x11`, `0x22`, `0x33`, `0x44` → beat addresses `0x8000_0010/14/18/1C`; `blk = 0x00000044_00000033_00000022_00000011`; `res.valid` at cycle 9, one cycle wide.
- **Cached writeback** at `0x100`, data lane i = i+1 → 4 consecutive write beats to `0x100`–`0x10C`, strobes `1111`, wdata 1..4; `res.valid` at cycle 5.
- **Uncached BYTE write** at `0x2000_0003`, `data=0xAB` → one beat, addr `0x2000_0000`, wstrb `1000`, wdata `0xAB000000`.
- **Uncached WORD read** at `0x2000_0008` with `mem_req_ready_i` low for 3 cycles and rvalid 2 cycles late → addr held stable; `blk[95:64]` = rdata, rest 0; exactly one `res.valid`.
- **Stray `mem_rvalid_i`** in IDLE or ISSUE → ignored. Async reset asserted during beat 2 of a read → outputs zero immediately; no `res.valid`; the next request after reset completes normally.
